// File: rtl/v_list_update_pipe_pkg.sv
// v_list_update_pipe_pkg: shared types for the list update pipe
// Sizes, command/error encodings and the per-context SRAM word
package v_list_update_pipe_pkg;

  localparam int CONTEXT_N = 128;
  localparam int ENTRIES_N = 4;
  localparam int KEY_W     = 32;
  localparam int SIZE_W    = 32;
  localparam int ID_W      = $clog2(CONTEXT_N);
  localparam int LS_W      = $clog2(ENTRIES_N + 1);

  typedef logic [ID_W-1:0] id_t;
  typedef logic [LS_W-1:0] listsize_t;

  typedef enum logic [1:0] {
    CMD_CLEAR   = 2'd0,
    CMD_ADD     = 2'd1,
    CMD_DELETE  = 2'd2,
    CMD_REPLACE = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    ERR_FULL     = 2'd0,
    ERR_DUP      = 2'd1,
    ERR_NOTFOUND = 2'd2
  } err_code_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } fsm_t;

  typedef struct packed {
    logic [KEY_W-1:0]  key;
    logic [SIZE_W-1:0] size;
  } entry_t;

  // entry[0] is the head; unused slots are kept at zero
  typedef struct packed {
    listsize_t                  listsize;
    entry_t [ENTRIES_N-1:0]     entry;
  } state_t;

  typedef struct packed {
    id_t               id;
    cmd_t              cmd;
    logic [KEY_W-1:0]  key;
    logic [SIZE_W-1:0] size;
  } upd_t;

endpackage

// File: rtl/v_list_update_pipe_if.sv
// v_list_update_pipe_if: update command bus
// Transfer happens on vld & rdy
interface v_list_update_pipe_if;
  import v_list_update_pipe_pkg::*;

  logic              vld;
  logic              rdy;
  id_t               prod_id;
  cmd_t              cmd;
  logic [KEY_W-1:0]  key;
  logic [SIZE_W-1:0] size;

  modport master (
    output vld, prod_id, cmd, key, size,
    input  rdy
  );

  modport slave (
    input  vld, prod_id, cmd, key, size,
    output rdy
  );

endinterface

// File: rtl/v_list_update_alu.sv
// v_list_update_alu: combinational sorted-list edit
// Errored ops return the old state unchanged
module v_list_update_alu
  import v_list_update_pipe_pkg::*;
(
  input  state_t            old_state,
  input  cmd_t              cmd,
  input  logic [KEY_W-1:0]  key,
  input  logic [SIZE_W-1:0] size,
  output state_t            new_state,
  output logic              err_vld,
  output err_code_t         err_code,
  output logic              lv0_changed
);

  logic      hit;
  logic      full;
  listsize_t hit_idx;
  listsize_t pos;
  entry_t    ins;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    pos     = '0;
    for (int i = 0; i < ENTRIES_N; i++) begin
      if (listsize_t'(i) < old_state.listsize) begin
        if (old_state.entry[i].key == key) begin
          hit     = 1'b1;
          hit_idx = listsize_t'(i);
        end
        if (old_state.entry[i].key > key)
          pos = pos + listsize_t'(1);
      end
    end
    full     = (old_state.listsize == listsize_t'(ENTRIES_N));
    ins.key  = key;
    ins.size = size;
  end

  always_comb begin
    new_state = old_state;
    err_vld   = 1'b0;
    err_code  = ERR_FULL;
    unique case (cmd)
      CMD_CLEAR: new_state = '0;
      CMD_ADD: begin
        if (full) begin
          err_vld  = 1'b1;
          err_code = ERR_FULL;
        end else if (hit) begin
          err_vld  = 1'b1;
          err_code = ERR_DUP;
        end else begin
          new_state.listsize = old_state.listsize + listsize_t'(1);
          for (int i = ENTRIES_N - 1; i > 0; i--)
            if (listsize_t'(i) > pos)
              new_state.entry[i] = old_state.entry[i-1];
          for (int i = 0; i < ENTRIES_N; i++)
            if (listsize_t'(i) == pos)
              new_state.entry[i] = ins;
        end
      end
      CMD_DELETE: begin
        if (!hit) begin
          err_vld  = 1'b1;
          err_code = ERR_NOTFOUND;
        end else begin
          new_state.listsize = old_state.listsize - listsize_t'(1);
          for (int i = 0; i < ENTRIES_N - 1; i++)
            if (listsize_t'(i) >= hit_idx)
              new_state.entry[i] = old_state.entry[i+1];
          new_state.entry[ENTRIES_N-1] = '0;
        end
      end
      CMD_REPLACE: begin
        if (!hit) begin
          err_vld  = 1'b1;
          err_code = ERR_NOTFOUND;
        end else begin
          for (int i = 0; i < ENTRIES_N; i++)
            if (listsize_t'(i) == hit_idx)
              new_state.entry[i].size = size;
        end
      end
    endcase
  end

  // empty lists hold a zero head, so the head compare covers key and size
  assign lv0_changed =
    ((new_state.listsize == '0) != (old_state.listsize == '0)) ||
    (new_state.entry[0] != old_state.entry[0]);

endmodule

// File: rtl/v_list_update_pipe.sv
// v_list_update_pipe: per-context sorted-list RMW pipe
// Init sweep, S1 forwarding, registered S2 write/lv0/err
module v_list_update_pipe
  import v_list_update_pipe_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  v_list_update_pipe_if.slave upd,
  output logic               o_state_ren,
  output id_t                o_state_raddr,
  input  state_t             i_state_rdata,
  output logic               o_state_wen,
  output id_t                o_state_waddr,
  output state_t             o_state_wdata,
  output logic               o_lv0_vld,
  output id_t                o_lv0_prod_id,
  output logic               o_lv0_empty,
  output logic [KEY_W-1:0]   o_lv0_key,
  output logic [SIZE_W-1:0]  o_lv0_size,
  output logic               o_err_vld,
  output err_code_t          o_err_code,
  output logic               o_busy
);

  fsm_t      state;
  fsm_t      state_nxt;
  id_t       init_cnt;
  logic      init_wr;
  logic      init_last;
  logic      acc;
  logic      s1_vld;
  upd_t      s1;
  logic      s2_vld;
  id_t       s2_id;
  state_t    s2_state;
  logic      s3_vld;
  id_t       s3_id;
  state_t    s3_state;
  state_t    old_state;
  state_t    new_state;
  logic      err_vld;
  err_code_t err_code;
  logic      lv0_chg;
  logic      wr;
  logic      lv0;
  logic      err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (init_wr)
        init_cnt <= init_cnt + id_t'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT: if (init_last) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    init_wr   = (state == ST_INIT);
    init_last = init_wr && (init_cnt == id_t'(CONTEXT_N - 1));
  end

  assign acc           = upd.vld & upd.rdy;
  assign o_state_ren   = acc;
  assign o_state_raddr = acc ? upd.prod_id : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s1     <= '0;
    end else begin
      s1_vld <= acc;
      if (acc) begin
        s1.id   <= upd.prod_id;
        s1.cmd  <= upd.cmd;
        s1.key  <= upd.key;
        s1.size <= upd.size;
      end
    end
  end

  // SRAM read misses writes from the two prior slots
  always_comb begin
    if (s2_vld && s2_id == s1.id)
      old_state = s2_state;
    else if (s3_vld && s3_id == s1.id)
      old_state = s3_state;
    else
      old_state = i_state_rdata;
  end

  v_list_update_alu u_alu (
    .old_state   (old_state),
    .cmd         (s1.cmd),
    .key         (s1.key),
    .size        (s1.size),
    .new_state   (new_state),
    .err_vld     (err_vld),
    .err_code    (err_code),
    .lv0_changed (lv0_chg)
  );

  assign wr  = s1_vld & ~err_vld;
  assign lv0 = s1_vld & lv0_chg;
  assign err = s1_vld & err_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld   <= 1'b0;
      s2_id    <= '0;
      s2_state <= '0;
      s3_vld   <= 1'b0;
      s3_id    <= '0;
      s3_state <= '0;
    end else begin
      s2_vld   <= s1_vld;
      s2_id    <= s1.id;
      s2_state <= new_state;
      s3_vld   <= s2_vld;
      s3_id    <= s2_id;
      s3_state <= s2_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd.rdy       <= 1'b0;
      o_busy        <= 1'b0;
      o_state_wen   <= 1'b0;
      o_state_waddr <= '0;
      o_state_wdata <= '0;
      o_lv0_vld     <= 1'b0;
      o_lv0_prod_id <= '0;
      o_lv0_empty   <= 1'b0;
      o_lv0_key     <= '0;
      o_lv0_size    <= '0;
      o_err_vld     <= 1'b0;
      o_err_code    <= ERR_FULL;
    end else begin
      upd.rdy       <= (state == ST_RUN);
      o_busy        <= init_wr;
      o_state_wen   <= init_wr | wr;
      o_state_waddr <= wr ? s1.id : (init_wr ? init_cnt : '0);
      o_state_wdata <= wr ? new_state : '0;
      o_lv0_vld     <= lv0;
      o_lv0_prod_id <= lv0 ? s1.id : '0;
      o_lv0_empty   <= lv0 & (new_state.listsize == '0);
      o_lv0_key     <= lv0 ? new_state.entry[0].key : '0;
      o_lv0_size    <= lv0 ? new_state.entry[0].size : '0;
      o_err_vld     <= err;
      o_err_code    <= err ? err_code : ERR_FULL;
    end
  end

endmodule

// File: tb/tb_v_list_update_pipe.sv
// tb_v_list_update_pipe: bench for the list update pipe
// Queue-based list model, behavioural 1R1W SRAM
module tb_v_list_update_pipe;
  import v_list_update_pipe_pkg::*;

  typedef struct packed {
    logic              wen;
    logic              lv0;
    logic              err;
    id_t               id;
    state_t            st;
    logic              empty;
    logic [KEY_W-1:0]  hkey;
    logic [SIZE_W-1:0] hsize;
    logic [1:0]        code;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  v_list_update_pipe_if upd_if ();

  logic              o_state_ren;
  id_t               o_state_raddr;
  state_t            rdata;
  logic              o_state_wen;
  id_t               o_state_waddr;
  state_t            o_state_wdata;
  logic              o_lv0_vld;
  id_t               o_lv0_prod_id;
  logic              o_lv0_empty;
  logic [KEY_W-1:0]  o_lv0_key;
  logic [SIZE_W-1:0] o_lv0_size;
  logic              o_err_vld;
  err_code_t         o_err_code;
  logic              o_busy;

  v_list_update_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .upd           (upd_if),
    .o_state_ren   (o_state_ren),
    .o_state_raddr (o_state_raddr),
    .i_state_rdata (rdata),
    .o_state_wen   (o_state_wen),
    .o_state_waddr (o_state_waddr),
    .o_state_wdata (o_state_wdata),
    .o_lv0_vld     (o_lv0_vld),
    .o_lv0_prod_id (o_lv0_prod_id),
    .o_lv0_empty   (o_lv0_empty),
    .o_lv0_key     (o_lv0_key),
    .o_lv0_size    (o_lv0_size),
    .o_err_vld     (o_err_vld),
    .o_err_code    (o_err_code),
    .o_busy        (o_busy)
  );

  // 1R1W SRAM: a same-edge read returns the old word
  state_t mem     [CONTEXT_N];
  bit     wr_seen [CONTEXT_N];
  always @(posedge clk) begin
    if (o_state_ren)
      rdata <= wr_seen[o_state_raddr] ? mem[o_state_raddr] : '1;
    if (o_state_wen) begin
      mem[o_state_waddr]     <= o_state_wdata;
      wr_seen[o_state_waddr] <= 1'b1;
    end
  end

  entry_t mq [CONTEXT_N][$];
  exp_t   pend [$];
  int     n_assert = 0;
  int     n_fail   = 0;

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_op(input id_t id, input int cmd,
                                    input logic [KEY_W-1:0] key,
                                    input logic [SIZE_W-1:0] size);
    exp_t   e;
    entry_t q [$];
    entry_t ins;
    int     idx;
    int     p;
    logic   oe;
    logic [KEY_W-1:0]  ok;
    logic [SIZE_W-1:0] os;
    e   = '0;
    e.id = id;
    q   = mq[id];
    oe  = (q.size() == 0);
    ok  = oe ? '0 : q[0].key;
    os  = oe ? '0 : q[0].size;
    idx = -1;
    foreach (q[i]) if (q[i].key == key) idx = i;
    case (cmd)
      0: q.delete();
      1: begin
        if (q.size() == ENTRIES_N) begin e.err = 1; e.code = 2'd0; end
        else if (idx >= 0) begin e.err = 1; e.code = 2'd1; end
        else begin
          p = q.size();
          foreach (q[i]) if (q[i].key < key && p == q.size()) p = i;
          ins.key  = key;
          ins.size = size;
          q.insert(p, ins);
        end
      end
      2: if (idx < 0) begin e.err = 1; e.code = 2'd2; end
         else q.delete(idx);
      default: if (idx < 0) begin e.err = 1; e.code = 2'd2; end
               else q[idx].size = size;
    endcase
    if (!e.err) begin
      mq[id]      = q;
      e.wen       = 1'b1;
      e.st        = '0;
      e.st.listsize = listsize_t'(q.size());
      foreach (q[i]) e.st.entry[i] = q[i];
      e.empty = (q.size() == 0);
      e.hkey  = e.empty ? '0 : q[0].key;
      e.hsize = e.empty ? '0 : q[0].size;
      e.lv0   = (e.empty != oe) || (e.hkey != ok) || (e.hsize != os);
    end
    return e;
  endfunction

  task automatic check_slot(input exp_t e);
    chk("wen", o_state_wen, e.wen);
    chk("lv0_vld", o_lv0_vld, e.lv0);
    chk("err_vld", o_err_vld, e.err);
    chk("rdy", upd_if.rdy, 1);
    if (e.wen) begin
      chk("waddr", o_state_waddr, e.id);
      chk("wdata", o_state_wdata, e.st);
    end
    if (e.lv0) begin
      chk("lv0_id", o_lv0_prod_id, e.id);
      chk("lv0_empty", o_lv0_empty, e.empty);
      chk("lv0_key", o_lv0_key, e.hkey);
      chk("lv0_size", o_lv0_size, e.hsize);
    end
    if (e.err) chk("err_code", o_err_code, e.code);
  endtask

  task automatic cyc(input bit v, input id_t id, input int cmd,
                     input logic [KEY_W-1:0] key,
                     input logic [SIZE_W-1:0] size);
    exp_t e;
    @(negedge clk);
    if (pend.size() >= 2) check_slot(pend.pop_front());
    upd_if.vld     = v;
    upd_if.prod_id = id;
    upd_if.cmd     = cmd_t'(cmd[1:0]);
    upd_if.key     = key;
    upd_if.size    = size;
    #1;
    chk("ren", o_state_ren, v);
    if (v) chk("raddr", o_state_raddr, id);
    e = '0;
    if (v) e = model_op(id, cmd, key, size);
    pend.push_back(e);
  endtask

  task automatic drain();
    repeat (3) cyc(0, '0, 0, '0, '0);
  endtask

  task automatic init_check();
    for (int i = 0; i < CONTEXT_N; i++) begin
      @(negedge clk);
      chk("init_busy", o_busy, 1);
      chk("init_wen", o_state_wen, 1);
      chk("init_waddr", o_state_waddr, i);
      chk("init_wdata", o_state_wdata, 0);
      chk("init_rdy", upd_if.rdy, 0);
    end
    @(negedge clk);
    chk("run_busy", o_busy, 0);
    chk("run_rdy", upd_if.rdy, 1);
    chk("run_wen", o_state_wen, 0);
  endtask

  task automatic rand_ops(input int n);
    int r;
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 9);
      if (r == 9)
        cyc(0, '0, 0, '0, '0);
      else
        cyc(1, id_t'($urandom_range(0, 3)),
            (r == 0) ? 0 : (r < 5) ? 1 : (r < 7) ? 2 : 3,
            KEY_W'($urandom_range(1, 8)), SIZE_W'($urandom));
    end
  endtask

  task automatic reset_outputs_check();
    chk("rst_busy", o_busy, 0);
    chk("rst_rdy", upd_if.rdy, 0);
    chk("rst_ren", o_state_ren, 0);
    chk("rst_raddr", o_state_raddr, 0);
    chk("rst_wen", o_state_wen, 0);
    chk("rst_wdata", o_state_wdata, 0);
    chk("rst_lv0", {o_lv0_vld, o_lv0_empty, o_lv0_key, o_lv0_size}, 0);
    chk("rst_err", {o_err_vld, o_err_code}, 0);
  endtask

  state_t s;
  state_t save9;

  initial begin
    upd_if.vld     = 1'b0;
    upd_if.prod_id = '0;
    upd_if.cmd     = CMD_CLEAR;
    upd_if.key     = '0;
    upd_if.size    = '0;
    repeat (3) @(negedge clk);
    reset_outputs_check();
    rst = 1'b1;
    init_check();

    cyc(1, 7'd5, 1, 10, 100);
    cyc(1, 7'd5, 1, 30, 300);
    cyc(1, 7'd5, 1, 20, 200);
    drain();
    s = '0;
    s.listsize = 3;
    s.entry[0] = {32'd30, 32'd300};
    s.entry[1] = {32'd20, 32'd200};
    s.entry[2] = {32'd10, 32'd100};
    chk("id5_mem", mem[5], s);

    cyc(1, 7'd7, 1, 1, 11);
    cyc(1, 7'd7, 1, 2, 12);
    cyc(1, 7'd7, 1, 3, 13);
    cyc(1, 7'd7, 1, 4, 14);
    cyc(1, 7'd7, 1, 5, 15);
    cyc(1, 7'd5, 1, 20, 9);
    cyc(1, 7'd5, 2, 99, 0);
    drain();
    chk("id5_mem_kept", mem[5], s);
    s = '0;
    s.listsize = 4;
    s.entry[0] = {32'd4, 32'd14};
    s.entry[1] = {32'd3, 32'd13};
    s.entry[2] = {32'd2, 32'd12};
    s.entry[3] = {32'd1, 32'd11};
    chk("id7_mem", mem[7], s);

    cyc(1, 7'd3, 1, 30, 1);
    cyc(1, 7'd3, 1, 20, 2);
    cyc(0, '0, 0, '0, '0);
    cyc(1, 7'd3, 2, 30, 0);
    cyc(1, 7'd3, 3, 20, 7);
    cyc(1, 7'd3, 0, 0, 0);
    cyc(1, 7'd3, 0, 0, 0);
    drain();
    chk("id3_mem", mem[3], 0);

    rand_ops(400);
    drain();

    save9 = mem[9];
    cyc(1, 7'd9, 1, 50, 1);
    cyc(1, 7'd9, 1, 60, 2);
    #1 rst = 1'b0;
    upd_if.vld = 1'b0;
    #1 reset_outputs_check();
    repeat (4) begin
      @(negedge clk);
      chk("rst_hold_wen", o_state_wen, 0);
      chk("rst_hold_busy", o_busy, 0);
    end
    chk("id9_no_write", mem[9], save9);
    pend.delete();
    foreach (mq[i]) mq[i].delete();
    rst = 1'b1;
    init_check();

    rand_ops(150);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/v_list_update_pipe.md
Name: v_list_update_pipe

Overview:
Parametrised successor to the per-context sorted-list update pipe. It accepts list update commands, performs a read-modify-write on an external 1R1W state SRAM (one word per context), and keeps each context's list sorted by descending key. It adds a post-reset SRAM initialisation sweep, same-context hazard forwarding, error reporting, and a level-0 change notify. It sits between the update bus and the state SRAM that the query pipe shares.

Parameters:
CONTEXT_N, 128, number of contexts (SRAM depth); power of two, >=2.
ENTRIES_N, 4, entries per context list; >=1.
KEY_W, 32, key width.
SIZE_W, 32, size width.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low (asserted at 0)
i_upd_vld  in  1  update valid
o_upd_rdy  out  1  update ready; transfer on vld&rdy
i_upd_prod_id  in  $clog2(CONTEXT_N)  context id
i_upd_cmd  in  2  CLEAR=0, ADD=1, DELETE=2, REPLACE=3
i_upd_key  in  KEY_W  key
i_upd_size  in  SIZE_W  size
o_state_ren  out  1  SRAM read enable
o_state_raddr  out  $clog2(CONTEXT_N)  SRAM read address
i_state_rdata  in  $bits(state_t)  SRAM read data, 1 cycle after ren
o_state_wen  out  1  SRAM write enable
o_state_waddr  out  $clog2(CONTEXT_N)  SRAM write address
o_state_wdata  out  $bits(state_t)  SRAM write data
o_lv0_vld  out  1  head-of-list changed
o_lv0_prod_id  out  $clog2(CONTEXT_N)  context of change
o_lv0_empty  out  1  list now empty
o_lv0_key  out  KEY_W  new head key (0 if empty)
o_lv0_size  out  SIZE_W  new head size (0 if empty)
o_err_vld  out  1  command rejected
o_err_code  out  2  FULL=0, DUP=1, NOTFOUND=2
o_busy  out  1  init sweep in progress

Behaviour:
- Reset: every output is 0, and o_busy is 0 for the reset duration. The FSM resets into INIT and all stage valids clear. A reset asserted mid-operation drops every in-flight op with no write, and a fresh sweep follows release.
- FSM INIT: the counter runs 0..CONTEXT_N-1; each cycle drives o_state_wen=1, waddr=counter, wdata=0 (empty list). o_busy=1 and o_upd_rdy=0 throughout. After the write to CONTEXT_N-1 the FSM moves to RUN. INIT takes exactly CONTEXT_N cycles.
- FSM RUN: o_upd_rdy=1 every cycle, with no backpressure. Every accepted op completes.
- state_t = {listsize ($clog2(ENTRIES_N+1) bits), entry[ENTRIES_N] of {key, size}}. entry[0] is the head (largest key). Valid entries are 0..listsize-1; unused entries are 0.
- Pipeline:
  - S0 (cycle T, accept): ren=1, raddr=prod_id; the op is registered into S1.
  - S1 (T+1): select the old state, compute the new state combinationally, register into S2.
  - S2 (T+2): wen=1 unless the op errored; drive waddr/wdata, lv0 and err outputs, all registered. Fixed latency is accept -> write = 2 cycles.
  - S3: holds the id and state of the op written in the previous cycle.
- Forwarding in S1, by priority:
  - S2 valid and same id -> S2 new state;
  - else S3 valid and same id -> S3 state;
  - else i_state_rdata.
  - The SRAM returns old data on a same-cycle read/write collision. Back-to-back ops to one id must behave as if serialised.
- Commands:
  - CLEAR: listsize=0, all entries zeroed. Never errors.
  - ADD: insert {key,size} at its sorted position and shift lower entries down. If listsize==ENTRIES_N -> FULL; if the key is already present -> DUP.
  - DELETE: remove the matching key and shift up. If the key is absent -> NOTFOUND.
  - REPLACE: overwrite the size of the matching key; order is unchanged. If the key is absent -> NOTFOUND.
- Errors: o_err_vld is a one-cycle pulse in the S2 slot. There is no write and no lv0 for that op. A forwarded state for an errored op equals its old state.
- lv0: o_lv0_vld pulses in the S2 slot when the post-op (empty, head key, head size) differs from the pre-op value. A CLEAR of an already-empty list produces no pulse.
- The S2 write and the S0 read may target the same address in the same cycle; forwarding covers this.

Decomposition:
- v_pkg additions: cmd_t enum, err_code_t enum, entry_t, state_t, KEY_W/SIZE_W/ENTRIES_N/CONTEXT_N-derived widths, and the listsize_t and id_t typedefs.
- One combinational sub-module, v_list_update_alu: (old state, cmd, key, size) -> (new state, err_vld, err_code, lv0_changed). The pipe, FSM and forwarding stay in v_list_update_pipe.

Test Plan:
- Release reset -> o_busy=1 for exactly 128 cycles with 128 writes of addr 0..127, data 0, o_upd_rdy=0 throughout; then rdy=1, busy=0.
- id 5: ADD key 10, ADD key 30, ADD key 20 -> final wdata listsize=3, keys [30,20,10]; lv0 pulses for the first two ADDs only (head 10, then 30).
- Back-to-back id 7: ADD 1, ADD 2, ADD 3, ADD 4 on consecutive cycles (SRAM returns stale 0) -> last write has keys [4,3,2,1] and listsize 4, proving S2 and S3 forwarding.
- Full context, ADD 5 -> err_vld with FULL, no wen. ADD with a duplicate key -> DUP. DELETE 99 (absent) -> NOTFOUND, state unchanged.
- id 3 holding [30,20]: DELETE 30 -> lv0 key 20. REPLACE 20 size 7 -> lv0 size 7. CLEAR -> lv0_empty=1. A second CLEAR -> no lv0.
- Assert rst with 2 ops in flight -> no wen for them, outputs 0, and a full 128-cycle INIT sweep after release.
